// File: rtl/param_ramp_ctrl.sv
// Slew-limited parameter ramp: moves the applied value toward target by at most STEP per
// accepted sample tick. Optional macro PARAM_RAMP_STALL_CNT_EN adds a dropped-tick counter.
module param_ramp_ctrl #(
    parameter int unsigned        WIDTH      = 24,
    parameter logic [WIDTH-1:0]   STEP       = 24'h000400,
    parameter logic [WIDTH-1:0]   INIT_VALUE = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] target,
    input  logic             sample_tick,
    output logic [WIDTH-1:0] param_out,
    output logic             param_valid,
    input  logic             param_ready,
    output logic             busy
`ifdef PARAM_RAMP_STALL_CNT_EN
    ,
    output logic [15:0]      stall_cnt
`endif
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        PUSH = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic [WIDTH-1:0] r_current;
    logic [WIDTH-1:0] w_next_current;
    logic             r_valid;
    logic             w_next_valid;
    logic [WIDTH:0]   w_up;
    logic [WIDTH:0]   w_dn;
    logic [WIDTH-1:0] w_up_clamped;
    logic [WIDTH-1:0] w_dn_clamped;

    // Extra bit keeps the sum/difference from wrapping; a set borrow bit means below zero.
    assign w_up = {1'b0, r_current} + {1'b0, STEP};
    assign w_dn = {1'b0, r_current} - {1'b0, STEP};

    // Clamp each candidate step so the ramp lands exactly on target.
    always_comb begin
        w_up_clamped = w_up[WIDTH-1:0];
        w_dn_clamped = w_dn[WIDTH-1:0];
        if (w_up > {1'b0, target}) begin
            w_up_clamped = target;
        end else begin
            w_up_clamped = w_up[WIDTH-1:0];
        end
        if (w_dn[WIDTH] || (w_dn[WIDTH-1:0] < target)) begin
            w_dn_clamped = target;
        end else begin
            w_dn_clamped = w_dn[WIDTH-1:0];
        end
    end

    // Next-state logic: ticks only step the ramp from IDLE; PUSH waits for acceptance.
    always_comb begin
        w_next_state   = r_state;
        w_next_current = r_current;
        w_next_valid   = r_valid;
        case (r_state)
            IDLE: begin
                if (sample_tick && (target > r_current)) begin
                    w_next_current = w_up_clamped;
                    w_next_valid   = 1'b1;
                    w_next_state   = PUSH;
                end else if (sample_tick && (target < r_current)) begin
                    w_next_current = w_dn_clamped;
                    w_next_valid   = 1'b1;
                    w_next_state   = PUSH;
                end else begin
                    w_next_state   = IDLE;
                end
            end
            PUSH: begin
                if (param_ready) begin
                    w_next_valid = 1'b0;
                    w_next_state = IDLE;
                end else begin
                    w_next_valid = 1'b1;
                    w_next_state = PUSH;
                end
            end
            default: begin
                w_next_valid = 1'b0;
                w_next_state = IDLE;
            end
        endcase
    end

    // State and applied-value registers; reset abandons any pending value.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= IDLE;
            r_current <= INIT_VALUE;
            r_valid   <= 1'b0;
        end else begin
            r_state   <= w_next_state;
            r_current <= w_next_current;
            r_valid   <= w_next_valid;
        end
    end

    assign param_out   = r_current;
    assign param_valid = r_valid;
    assign busy        = (r_current != target) || r_valid;

`ifdef PARAM_RAMP_STALL_CNT_EN
    logic        w_drop;
    logic [15:0] r_stall_cnt;

    assign w_drop = (r_state == PUSH) && sample_tick;

    // Saturating count of ticks discarded while a value awaits acceptance.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall_cnt <= 16'h0000;
        end else if (w_drop && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'h0001;
        end else begin
            r_stall_cnt <= r_stall_cnt;
        end
    end

    assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_param_ramp_ctrl.sv
// Directed bench for param_ramp_ctrl: default-STEP instance plus a wide-STEP instance.
module tb_param_ramp_ctrl;

    logic        clk;
    logic        reset;
    logic [23:0] target;
    logic        sample_tick;
    logic [23:0] param_out;
    logic        param_valid;
    logic        param_ready;
    logic        busy;
    logic [23:0] target2;
    logic        tick2;
    logic [23:0] out2;
    logic        valid2;
    logic        ready2;
    logic        busy2;
`ifdef PARAM_RAMP_STALL_CNT_EN
    logic [15:0] stall_cnt;
    logic [15:0] stall_cnt2;
`endif

    int pass_cnt = 0;
    int chk_cnt  = 0;

    param_ramp_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .target      (target),
        .sample_tick (sample_tick),
        .param_out   (param_out),
        .param_valid (param_valid),
        .param_ready (param_ready),
        .busy        (busy)
`ifdef PARAM_RAMP_STALL_CNT_EN
        ,
        .stall_cnt   (stall_cnt)
`endif
    );

    param_ramp_ctrl #(.WIDTH(24), .STEP(24'h800000), .INIT_VALUE(24'h000000)) dut_wide (
        .clk         (clk),
        .reset       (reset),
        .target      (target2),
        .sample_tick (tick2),
        .param_out   (out2),
        .param_valid (valid2),
        .param_ready (ready2),
        .busy        (busy2)
`ifdef PARAM_RAMP_STALL_CNT_EN
        ,
        .stall_cnt   (stall_cnt2)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        chk_cnt++;
        if (param_out !== 24'h000000) $display("FAIL reset_out got %h exp %h", param_out, 24'h000000);
        else pass_cnt++;
        chk_cnt++;
        if (param_valid !== 1'b0) $display("FAIL reset_valid got %b exp 0", param_valid);
        else pass_cnt++;
        chk_cnt++;
        if (busy !== 1'b0) $display("FAIL reset_busy got %b exp 0", busy);
        else pass_cnt++;
    endtask

    task automatic test_ramp_up();
        logic [23:0] exp_v [4] = '{24'h000400, 24'h000800, 24'h000C00, 24'h001000};
        param_ready = 1'b1;
        target      = 24'h001000;
        for (int k = 0; k < 4; k++) begin
            sample_tick = 1'b1;
            step(1);
            sample_tick = 1'b0;
            chk_cnt++;
            if (param_out !== exp_v[k] || param_valid !== 1'b1)
                $display("FAIL up_step%0d got %h/%b exp %h/1", k, param_out, param_valid, exp_v[k]);
            else pass_cnt++;
            step(1);
            chk_cnt++;
            if (param_valid !== 1'b0 || busy !== (k != 3))
                $display("FAIL up_accept%0d got valid=%b busy=%b exp valid=0 busy=%b", k, param_valid, busy, (k != 3));
            else pass_cnt++;
            step(6);
        end
        sample_tick = 1'b1;
        step(1);
        sample_tick = 1'b0;
        chk_cnt++;
        if (param_out !== 24'h001000 || param_valid !== 1'b0)
            $display("FAIL up_hold got %h/%b exp 001000/0", param_out, param_valid);
        else pass_cnt++;
    endtask

    task automatic test_ramp_down();
        logic [23:0] exp_v [4] = '{24'h000C00, 24'h000800, 24'h000400, 24'h000300};
        param_ready = 1'b1;
        target      = 24'h000300;
        for (int k = 0; k < 4; k++) begin
            step(2);
            sample_tick = 1'b1;
            step(1);
            sample_tick = 1'b0;
            chk_cnt++;
            if (param_out !== exp_v[k] || param_valid !== 1'b1)
                $display("FAIL down_step%0d got %h/%b exp %h/1", k, param_out, param_valid, exp_v[k]);
            else pass_cnt++;
            step(1);
        end
        chk_cnt++;
        if (busy !== 1'b0) $display("FAIL down_busy got %b exp 0", busy);
        else pass_cnt++;
    endtask

    task automatic test_stall();
        reset = 1'b1;
        step(1);
        reset       = 1'b0;
        param_ready = 1'b0;
        target      = 24'h001000;
        sample_tick = 1'b1;
        step(1);
        sample_tick = 1'b0;
        for (int j = 0; j < 3; j++) begin
            step(2);
            sample_tick = 1'b1;
            step(1);
            sample_tick = 1'b0;
            chk_cnt++;
            if (param_out !== 24'h000400 || param_valid !== 1'b1)
                $display("FAIL stall_hold%0d got %h/%b exp 000400/1", j, param_out, param_valid);
            else pass_cnt++;
        end
`ifdef PARAM_RAMP_STALL_CNT_EN
        chk_cnt++;
        if (stall_cnt !== 16'd3) $display("FAIL stall_cnt3 got %0d exp 3", stall_cnt);
        else pass_cnt++;
`endif
        // Tick in the same cycle as acceptance must be dropped.
        param_ready = 1'b1;
        sample_tick = 1'b1;
        step(1);
        sample_tick = 1'b0;
        param_ready = 1'b0;
        chk_cnt++;
        if (param_out !== 24'h000400 || param_valid !== 1'b0)
            $display("FAIL stall_accept_drop got %h/%b exp 000400/0", param_out, param_valid);
        else pass_cnt++;
`ifdef PARAM_RAMP_STALL_CNT_EN
        chk_cnt++;
        if (stall_cnt !== 16'd4) $display("FAIL stall_cnt4 got %0d exp 4", stall_cnt);
        else pass_cnt++;
`endif
        sample_tick = 1'b1;
        step(1);
        sample_tick = 1'b0;
        chk_cnt++;
        if (param_out !== 24'h000800 || param_valid !== 1'b1)
            $display("FAIL stall_resume got %h/%b exp 000800/1", param_out, param_valid);
        else pass_cnt++;
    endtask

    task automatic test_reset_in_push();
        reset       = 1'b1;
        sample_tick = 1'b1;
        param_ready = 1'b1;
        step(1);
        reset       = 1'b0;
        sample_tick = 1'b0;
        chk_cnt++;
        if (param_out !== 24'h000000 || param_valid !== 1'b0)
            $display("FAIL push_reset got %h/%b exp 000000/0", param_out, param_valid);
        else pass_cnt++;
`ifdef PARAM_RAMP_STALL_CNT_EN
        chk_cnt++;
        if (stall_cnt !== 16'd0) $display("FAIL push_reset_cnt got %0d exp 0", stall_cnt);
        else pass_cnt++;
`endif
        step(1);
        chk_cnt++;
        if (param_out !== 24'h000000 || param_valid !== 1'b0 || busy !== 1'b1)
            $display("FAIL push_reset_tick got %h/%b/%b exp 000000/0/1", param_out, param_valid, busy);
        else pass_cnt++;
    endtask

    task automatic test_redirect();
        reset = 1'b1;
        step(1);
        reset       = 1'b0;
        param_ready = 1'b1;
        target      = 24'h002000;
        for (int k = 0; k < 2; k++) begin
            sample_tick = 1'b1;
            step(1);
            sample_tick = 1'b0;
            step(3);
        end
        target = 24'h000000;
        step(1);
        chk_cnt++;
        if (param_out !== 24'h000800 || busy !== 1'b1)
            $display("FAIL redirect_pre got %h/%b exp 000800/1", param_out, busy);
        else pass_cnt++;
        sample_tick = 1'b1;
        step(1);
        sample_tick = 1'b0;
        chk_cnt++;
        if (param_out !== 24'h000400 || param_valid !== 1'b1)
            $display("FAIL redirect_step got %h/%b exp 000400/1", param_out, param_valid);
        else pass_cnt++;
    endtask

    task automatic test_wide_no_wrap();
        logic [23:0] exp_v [3] = '{24'h800000, 24'hFFFFFF, 24'hFFFFFF};
        logic        exp_vl [3] = '{1'b1, 1'b1, 1'b0};
        ready2  = 1'b1;
        target2 = 24'hFFFFFF;
        for (int k = 0; k < 3; k++) begin
            tick2 = 1'b1;
            step(1);
            tick2 = 1'b0;
            chk_cnt++;
            if (out2 !== exp_v[k] || valid2 !== exp_vl[k])
                $display("FAIL wide_step%0d got %h/%b exp %h/%b", k, out2, valid2, exp_v[k], exp_vl[k]);
            else pass_cnt++;
            step(2);
        end
        chk_cnt++;
        if (busy2 !== 1'b0) $display("FAIL wide_busy got %b exp 0", busy2);
        else pass_cnt++;
    endtask

    initial begin
        reset       = 1'b1;
        target      = 24'h000000;
        sample_tick = 1'b0;
        param_ready = 1'b0;
        target2     = 24'h000000;
        tick2       = 1'b0;
        ready2      = 1'b0;
        step(2);
        test_reset();
        test_ramp_up();
        test_ramp_down();
        test_stall();
        test_reset_in_push();
        test_redirect();
        test_wide_no_wrap();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
